// File: rtl/comb_stack_engine.sv
// Binomial coefficient engine: evaluates C(n,k) by depth-first expansion of Pascal's rule
// on an internal (n,k) stack, counting leaves into a saturating result accumulator.
module comb_stack_engine #(
   parameter int unsigned NW    = 8,
   parameter int unsigned RW    = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NW-1:0]              n_in,
   input  logic [NW-1:0]              k_in,
   output logic                       busy,
   output logic                       done,
   output logic [RW-1:0]              result,
   output logic                       err,
   output logic [1:0]                 err_code,
   output logic [$clog2(DEPTH+1)-1:0] peak_depth
);
   localparam int unsigned SPW = $clog2(DEPTH + 1);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SPW-1:0] SpFull = SPW'(DEPTH);
   localparam logic [SPW-1:0] SpOne  = SPW'(1);
   localparam logic [NW-1:0]  NOne   = NW'(1);
   localparam logic [RW-1:0]  ROne   = RW'(1);

   typedef enum logic [3:0] {
      StIdle, StInit, StPop, StEval, StAcc, StPushA, StPushB, StFin, StErr
   } state_e;

   state_e state_q, state_d;

   logic [NW-1:0]   n_q, n_d, k_q, k_d;
   logic [NW-1:0]   cur_n_q, cur_n_d, cur_k_q, cur_k_d;
   logic [RW-1:0]   result_q, result_d;
   logic            err_q, err_d;
   logic [1:0]      code_q, code_d;
   logic [SPW-1:0]  sp_q, sp_d, peak_q, peak_d;

   logic [2*NW-1:0] mem_q [DEPTH];
   logic            wr_en;
   logic [2*NW-1:0] wr_data, rd_data;
   logic [AW-1:0]   wr_addr, rd_addr;

   assign wr_addr = AW'(sp_q);
   assign rd_addr = AW'(sp_q - SpOne);
   assign rd_data = mem_q[rd_addr];

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q      <= '0;
         k_q      <= '0;
         cur_n_q  <= '0;
         cur_k_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         code_q   <= 2'b00;
         sp_q     <= '0;
         peak_q   <= '0;
      end else begin
         n_q      <= n_d;
         k_q      <= k_d;
         cur_n_q  <= cur_n_d;
         cur_k_q  <= cur_k_d;
         result_q <= result_d;
         err_q    <= err_d;
         code_q   <= code_d;
         sp_q     <= sp_d;
         peak_q   <= peak_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      k_d      = k_q;
      cur_n_d  = cur_n_q;
      cur_k_d  = cur_k_q;
      result_d = result_q;
      err_d    = err_q;
      code_d   = code_q;
      sp_d     = sp_q;
      peak_d   = peak_q;
      wr_en    = 1'b0;
      wr_data  = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               n_d      = n_in;
               k_d      = k_in;
               result_d = '0;
               err_d    = 1'b0;
               code_d   = 2'b00;
               peak_d   = '0;
               state_d  = StInit;
            end
         end
         StInit: begin
            if (k_q > n_q) begin
               state_d = StFin;
            end else begin
               wr_en   = 1'b1;
               wr_data = {n_q, k_q};
               sp_d    = sp_q + SpOne;
               state_d = StPop;
            end
         end
         StPop: begin
            if (sp_q == '0) begin
               state_d = StFin;
            end else begin
               cur_n_d = rd_data[2*NW-1:NW];
               cur_k_d = rd_data[NW-1:0];
               sp_d    = sp_q - SpOne;
               state_d = StEval;
            end
         end
         StEval: begin
            state_d = (cur_k_q == '0 || cur_k_q == cur_n_q) ? StAcc : StPushA;
         end
         StAcc: begin
            // Saturate rather than wrap so the reported value is a lower bound
            if (&result_q) begin
               err_d   = 1'b1;
               code_d  = 2'b10;
               state_d = StErr;
            end else begin
               result_d = result_q + ROne;
               state_d  = StPop;
            end
         end
         StPushA, StPushB: begin
            if (sp_q == SpFull) begin
               err_d   = 1'b1;
               code_d  = 2'b01;
               state_d = StErr;
            end else begin
               wr_en   = 1'b1;
               wr_data = (state_q == StPushA) ? {cur_n_q - NOne, cur_k_q - NOne}
                                              : {cur_n_q - NOne, cur_k_q};
               sp_d    = sp_q + SpOne;
               state_d = (state_q == StPushA) ? StPushB : StPop;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         StErr: begin
            sp_d    = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (wr_en && sp_d > peak_q) peak_d = sp_d;
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StFin) || (state_q == StErr);
   end

   assign result     = result_q;
   assign err        = err_q;
   assign err_code   = code_q;
   assign peak_depth = peak_q;

endmodule
